rxdata_fifo_rdctl: RTL
======================

// Module: rxdata_fifo_rdctl
// PURPOSE
//  Read-side sequencer for the LMAC RX data path. Pops one packet descriptor from the
//  RX info FIFO, then drains exactly ceil(len/32) 256-bit words from the rxdata
//  1024x256 FIFO. Presents the words as an AXI4-Stream master with tkeep/tlast/tuser.
//  Sits in the read-clock domain of both FIFOs, between them and the AXIS bridge output.
// PARAMETERS
//  WIDTH    256  data word width (bits); BYTES = WIDTH/8 = 32
//  PTR      10   FIFO pointer width; usedw ports are PTR+1 bits
//  INFO_W   16   descriptor width: [13:0] len bytes, [14] err, [15] reserved
//  CNT_W    32   statistics counter width
// PORTS
//  clk            in   1        single clock (= rdclk of both FIFOs)
//  reset_         in   1        async active-low reset
//  info_rdempty   in   1        descriptor FIFO empty
//  info_rden      out  1        descriptor FIFO read request
//  info_dataout   in   INFO_W   descriptor, valid the cycle after info_rden
//  data_rdempty   in   1        rxdata FIFO empty
//  data_rden      out  1        rxdata FIFO read request
//  data_dataout   in   WIDTH    data word, valid the cycle after data_rden
//  m_axis_tvalid  out  1        stream valid
//  m_axis_tready  in   1        stream ready
//  m_axis_tdata   out  WIDTH    stream data, byte 0 = [7:0]
//  m_axis_tkeep   out  WIDTH/8  byte enables, low bytes first
//  m_axis_tlast   out  1        last beat of packet
//  m_axis_tuser   out  1        descriptor err bit, driven on every beat of the packet
//  pkt_cnt        out  CNT_W    packets whose last data read was issued (wraps)
//  zlen_cnt       out  CNT_W    zero-length descriptors discarded (wraps)
//  busy           out  1        state != IDLE or output buffer non-empty
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; buffer empty; counters 0. Reset mid-packet abandons
//   the packet (FIFOs are reset by the same reset_).
//  FSM: IDLE -> INFO_WAIT when !info_rdempty (info_rden=1 for exactly that cycle).
//   INFO_WAIT: capture len, err; beats = (len+31)>>5; rem = len[4:0].
//    len==0 -> zlen_cnt++, go to IDLE with no data read. Else go to STREAM.
//   STREAM: data_rden = !data_rdempty && (occ + inflight) < 2; each read decrements beats.
//    The read that takes beats to 0 -> pkt_cnt++, go to IDLE.
//  inflight = data_rden of the previous cycle (read latency fixed at 1). occ = buffer count 0..2.
//  Tag pipeline: {last, keep, err} are computed at read issue, delayed 1 cycle, and
//   written into the buffer alongside data_dataout.
//   keep = all ones, except on the last beat with rem!=0, where keep = (1<<rem)-1.
//  Output buffer: 2-entry FIFO. tvalid = occ!=0. Pop on tvalid&&tready.
//   Simultaneous push and pop keeps occ unchanged. Never overflows, by the credit rule.
//  AXIS rules: tdata/tkeep/tlast/tuser are stable while tvalid && !tready.
//   tvalid never drops without a handshake.
//  Latency: info_rden at cycle 0; first data_rden at cycle 2; tvalid at cycle 4.
//  Throughput: 1 beat/clk sustained while tready=1 and data present.
//  Inter-packet gap: 2 cycles of no reads. The previous packet's beats continue to drain
//   meanwhile, in order.
//  data_rdempty mid-packet: stall the read, keep state; no bubble-filling or timeout.
//  info_rden and data_rden are never asserted while the matching empty flag is 1.
// STRUCTURE
//  Package lmac_rx_pkg: state encodings (IDLE, INFO_WAIT, STREAM); INFO field offsets
//   (LEN_LSB=0, LEN_MSB=13, ERR_BIT=14); BYTES localparam.
//  Sub-module rxaxis_skid2: 2-entry valid/ready buffer, width WIDTH+WIDTH/8+2.
//  Top level contains the FSM, beat counter, credit logic, tag pipeline and counters.
// TESTING
//  1 desc len=64, data ready, tready=1 -> 2 beats, keep=FFFFFFFF both, tlast on beat 2,
//    tvalid first at cycle 4; pkt_cnt=1.
//  2 len=33 -> 2 beats; beat 2 keep=00000001, tlast=1. len=31 -> 1 beat, keep=7FFFFFFF.
//  3 len=0 desc followed by len=32 desc -> zlen_cnt=1; one beat out; data_rden count = 1.
//  4 tready toggled randomly, 3 back-to-back packets (len 100, 32, 1500) with err bit on
//    pkt 2 -> data in order, no loss or duplicate; tuser=1 only on pkt 2;
//    occ never exceeds 2; outputs held during stall.
//  5 data_rdempty=1 for 10 cycles mid-packet -> no data_rden during the stall;
//    packet completes intact afterwards.
//  6 reset_ low mid-packet for 1 cycle -> all outputs 0 immediately;
//    a fresh len=64 packet afterwards streams correctly.

Source files
------------

// File: rtl/lmac_rx_pkg.sv
// rtl/lmac_rx_pkg.sv - shared encodings and descriptor layout for the LMAC RX read path
// Purpose: FSM state encoding, descriptor field offsets, word geometry and the
//          length-to-beat conversion used by the RX data FIFO read sequencer.
// Ports:   none (package).
package lmac_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_INFO_WAIT = 2'd1,
    ST_STREAM    = 2'd2
  } state_e;

  localparam int BYTES   = 32;
  localparam int REM_W   = $clog2(BYTES);
  localparam int PTR     = 10;

  localparam int LEN_LSB = 0;
  localparam int LEN_MSB = 13;
  localparam int ERR_BIT = 14;
  localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;
  // One extra bit: a maximum-length descriptor rounds up to 2^(LEN_W-REM_W) beats.
  localparam int BEAT_W  = LEN_W - REM_W + 1;

  function automatic logic [BEAT_W-1:0] len_to_beats(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W+1)'(BYTES - 1);
    return sum[LEN_W:REM_W];
  endfunction

endpackage

// File: rtl/rxaxis_skid2.sv
// rtl/rxaxis_skid2.sv - two-entry valid/ready output buffer
// Purpose: holds up to two words between the FIFO read pipeline and the stream
//          output; the head entry is stable until it is popped.
// Ports:   clk/reset_   clock, async active-low reset
//          s_valid/s_data   push side (no backpressure; caller guarantees space)
//          m_valid/m_ready/m_data   pop side, handshake on m_valid && m_ready
//          occ          current entry count 0..2
module rxaxis_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic [1:0]   occ
);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop;

  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = rd_ptr_q ? ent1_q : ent0_q;
  assign occ     = cnt_q;
  assign pop     = m_valid && m_ready;

  always_comb begin
    ent0_d   = ent0_q;
    ent1_d   = ent1_q;
    if (s_valid) begin
      if (wr_ptr_q) ent1_d = s_data;
      else          ent0_d = s_data;
    end
    wr_ptr_d = wr_ptr_q ^ s_valid;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, s_valid} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      ent0_q   <= '0;
      ent1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      ent0_q   <= ent0_d;
      ent1_q   <= ent1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/rxdata_fifo_rdctl.sv
// rtl/rxdata_fifo_rdctl.sv - RX data FIFO read sequencer with AXI4-Stream output
// Purpose: pops one descriptor, then reads ceil(len/32) words from the rxdata
//          FIFO and presents them as a stream with tkeep/tlast/tuser.
// Ports:   clk/reset_            clock, async active-low reset
//          info_rdempty/info_rden/info_dataout   descriptor FIFO read port (1-cycle latency)
//          data_rdempty/data_rden/data_dataout   data FIFO read port (1-cycle latency)
//          m_axis_*              stream master
//          pkt_cnt/zlen_cnt      wrapping packet and zero-length descriptor counters
//          busy                  FSM active or output buffer non-empty
module rxdata_fifo_rdctl
  import lmac_rx_pkg::*;
#(
  parameter int WIDTH  = 256,
  parameter int INFO_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset_,
  input  logic               info_rdempty,
  output logic               info_rden,
  input  logic [INFO_W-1:0]  info_dataout,
  input  logic               data_rdempty,
  output logic               data_rden,
  input  logic [WIDTH-1:0]   data_dataout,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [WIDTH-1:0]   m_axis_tdata,
  output logic [WIDTH/8-1:0] m_axis_tkeep,
  output logic               m_axis_tlast,
  output logic               m_axis_tuser,
  output logic [CNT_W-1:0]   pkt_cnt,
  output logic [CNT_W-1:0]   zlen_cnt,
  output logic               busy
);

  localparam int KEEP_W = WIDTH / 8;
  localparam int TAG_W  = KEEP_W + 2;
  localparam int BUF_W  = WIDTH + TAG_W;

  state_e              state_q, state_d;
  logic                en_q, en_d;
  logic [BEAT_W-1:0]   beats_q, beats_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic                err_q, err_d;
  logic                inflight_q, inflight_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]    zlen_cnt_q, zlen_cnt_d;

  logic [LEN_W-1:0]    info_len;
  logic                info_err;
  logic [INFO_W-ERR_BIT-2:0] info_rsvd_unused;
  logic                last_read;
  logic [KEEP_W-1:0]   keep_part;
  logic                tag_last;
  logic [KEEP_W-1:0]   tag_keep;
  logic [1:0]          occ;
  logic [1:0]          occ_eff;
  logic                pop;
  logic                credit_ok;
  logic [BUF_W-1:0]    buf_dout;

  assign info_len         = info_dataout[LEN_MSB:LEN_LSB];
  assign info_err         = info_dataout[ERR_BIT];
  assign info_rsvd_unused = info_dataout[INFO_W-1:ERR_BIT+1];

  assign last_read = (beats_q == BEAT_W'(1));
  assign keep_part = ~({KEEP_W{1'b1}} << rem_q);

  // A beat leaving the buffer this cycle frees its slot for the read issued this
  // cycle; counting that pop is what sustains one read per clock with tready high.
  assign pop       = m_axis_tvalid && m_axis_tready;
  assign occ_eff   = occ - {1'b0, pop};
  assign credit_ok = (occ_eff + {1'b0, inflight_q}) < 2'd2;

  // en_q keeps info_rden low while reset_ is asserted and for the first edge after.
  assign en_d       = 1'b1;
  assign inflight_d = data_rden;

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (info_rden) state_d = ST_INFO_WAIT;
      ST_INFO_WAIT: state_d = (info_len == '0) ? ST_IDLE : ST_STREAM;
      ST_STREAM:    if (data_rden && last_read) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin : fsm_outputs
    info_rden = 1'b0;
    data_rden = 1'b0;
    case (state_q)
      ST_IDLE:   info_rden = en_q && !info_rdempty;
      ST_STREAM: data_rden = !data_rdempty && credit_ok;
      default:   ;
    endcase
  end

  always_comb begin : datapath
    beats_d    = beats_q;
    rem_d      = rem_q;
    err_d      = err_q;
    pkt_cnt_d  = pkt_cnt_q;
    zlen_cnt_d = zlen_cnt_q;
    tag_last   = 1'b0;
    tag_keep   = {KEEP_W{1'b1}};
    if (state_q == ST_INFO_WAIT) begin
      beats_d = len_to_beats(info_len);
      rem_d   = info_len[REM_W-1:0];
      err_d   = info_err;
      if (info_len == '0) zlen_cnt_d = zlen_cnt_q + CNT_W'(1);
    end
    if (data_rden) begin
      beats_d  = beats_q - BEAT_W'(1);
      tag_last = last_read;
      if (last_read) begin
        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        if (rem_q != '0) tag_keep = keep_part;
      end
    end
    // Tags ride one cycle behind the read so they meet data_dataout at the buffer.
    tag_d = {tag_last, tag_keep, err_q};
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      beats_q    <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      pkt_cnt_q  <= '0;
      zlen_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      beats_q    <= beats_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      pkt_cnt_q  <= pkt_cnt_d;
      zlen_cnt_q <= zlen_cnt_d;
    end
  end

  rxaxis_skid2 #(.W(BUF_W)) u_obuf (
    .clk     (clk),
    .reset_  (reset_),
    .s_valid (inflight_q),
    .s_data  ({data_dataout, tag_q}),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready),
    .m_data  (buf_dout),
    .occ     (occ)
  );

  assign {m_axis_tdata, m_axis_tlast, m_axis_tkeep, m_axis_tuser} = buf_dout;
  assign pkt_cnt  = pkt_cnt_q;
  assign zlen_cnt = zlen_cnt_q;
  assign busy     = (state_q != ST_IDLE) || (occ != 2'd0);

endmodule
